fetch_redirect_ctrl: RTL and testbench
======================================

Name: fetch_redirect_ctrl

Overview:
- Arbitrates every PC redirect request to the IF stage and issues at most one per cycle. Sources, highest priority first: MEM-stage resolution, ID-stage resolution, IF-side predictor target.
- Produces the single Request_Alt_PC/Alt_PC pair for IF and the FLUSH for the front-end stage registers.
- Holds a redirect that arrives while the front end is stalled, and suppresses wrong-path younger redirects after a MEM redirect.
- Keeps per-source saturating redirect counters for predictor evaluation.

Parameters:
- SHADOW_CYCLES, 2, cycles after an issued MEM redirect during which ID and predictor requests are ignored (0 disables).
- CNT_W, 16, width of each redirect statistics counter.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- STALL  in  1  front end frozen this cycle.
- mem_redirect_valid  in  1  MEM stage requests redirect.
- mem_redirect_pc  in  32  MEM redirect target.
- id_redirect_valid  in  1  ID stage requests redirect.
- id_redirect_pc  in  32  ID redirect target.
- pred_valid  in  1  predictor predicts taken.
- pred_pc  in  32  predicted target.
- Request_Alt_PC  out  1  one-cycle redirect strobe to IF.
- Alt_PC  out  32  redirect target; valid while Request_Alt_PC=1.
- FLUSH  out  1  squash front-end stage registers.
- pending  out  1  a redirect is held awaiting STALL release.
- cnt_mem  out  CNT_W  issued MEM redirects.
- cnt_id  out  CNT_W  issued ID redirects.
- cnt_pred  out  CNT_W  issued predictor redirects.

Behaviour:
- Reset (RESET=0, async, any cycle including mid-hold or mid-shadow):
  - Request_Alt_PC=0, FLUSH=0, Alt_PC=0, pending=0.
  - Pending source/PC cleared, shadow counter=0, all counters=0.
- Eligibility per cycle:
  - mem is always eligible.
  - id and pred are eligible only when shadow_cnt==0.
- Winner selection, first match wins: held request (if pending), then eligible mem, then eligible id, then eligible pred.
- Exception to held-first: an incoming eligible source of strictly higher priority than the held source replaces it. Equal or lower priority incoming requests are dropped.
- All outputs are registered; latency is 1 cycle from input to Request_Alt_PC.
- Edge with STALL=0 and a winner:
  - Request_Alt_PC<=1 and Alt_PC<=winner PC.
  - FLUSH<=1 if the winner is MEM or ID, 0 if PRED.
  - pending<=0.
  - The winner's counter increments, saturating at 2^CNT_W-1.
  - If the winner is MEM, shadow_cnt<=SHADOW_CYCLES.
- Edge with STALL=1 and a winner:
  - The winner is latched as held, pending<=1.
  - Request_Alt_PC<=0, FLUSH<=0; no counter changes.
- Edge with no winner: Request_Alt_PC<=0, FLUSH<=0; Alt_PC holds its last value.
- shadow_cnt decrements by 1 on each edge with STALL=0 and shadow_cnt>0, except on an edge that reloads it. It is frozen while STALL=1.
- Request_Alt_PC is never asserted in two consecutive cycles from the same held entry. A held request is issued exactly once, on the first edge with STALL=0.
- States:
  - IDLE: no hold, shadow_cnt=0.
  - HOLD: pending=1.
  - SHADOW: shadow_cnt>0.
  - HOLD and SHADOW may coexist. A hold entered during SHADOW can only be from MEM.
- Simultaneous mem+id+pred with STALL=0: MEM is issued; the ID and PRED requests are discarded, not queued.

Test Plan:
- After reset release, pulse id_redirect_valid with id_redirect_pc=0x00400100, STALL=0 -> next cycle Request_Alt_PC=1, Alt_PC=0x00400100, FLUSH=1, cnt_id=1; the cycle after, Request_Alt_PC=0.
- In one cycle, mem_redirect_pc=0x00400200, id_redirect_pc=0x00400300, pred_pc=0x00400400, all valid -> Alt_PC=0x00400200, FLUSH=1, cnt_mem=1.
  - ID requests on the next 2 cycles are ignored (no Request_Alt_PC, cnt_id unchanged).
  - On the 3rd cycle an ID request is issued.
- STALL=1 for 3 cycles with pred_valid=1, pred_pc=0x00400040 in cycle 1, then id_redirect_pc=0x00400080 in cycle 2:
  - pending=1 throughout; no Request_Alt_PC while stalled.
  - On STALL release, a single strobe issues with Alt_PC=0x00400080, FLUSH=1, cnt_pred=0.
- While pending holds an ID request under STALL, drive RESET=0 -> pending, Request_Alt_PC and the counters go to 0 immediately. After STALL drops, no redirect is issued.
- Force cnt_pred to 0xFFFE (or issue 65535 predictor redirects) -> the count reaches 0xFFFF and stays at 0xFFFF on further predictor redirects. FLUSH=0 on each.

Source files
------------

// File: rtl/fetch_redirect_ctrl.sv
// fetch_redirect_ctrl: arbitrates PC redirect requests (MEM > ID > predictor)
// into one registered redirect strobe per cycle for the IF stage.
//   CLK, RESET (async, active-low)        clock / reset
//   STALL                                 front end frozen this cycle
//   mem/id_redirect_valid, *_pc           resolved redirect requests
//   pred_valid, pred_pc                   predictor taken target
//   Request_Alt_PC, Alt_PC                one-cycle redirect strobe + target
//   FLUSH                                 squash front-end stage registers
//   pending                               redirect held awaiting STALL release
//   cnt_mem, cnt_id, cnt_pred             saturating issued-redirect counters
module fetch_redirect_ctrl #(
    parameter int unsigned SHADOW_CYCLES = 2,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             STALL,
    input  logic             mem_redirect_valid,
    input  logic [31:0]      mem_redirect_pc,
    input  logic             id_redirect_valid,
    input  logic [31:0]      id_redirect_pc,
    input  logic             pred_valid,
    input  logic [31:0]      pred_pc,
    output logic             Request_Alt_PC,
    output logic [31:0]      Alt_PC,
    output logic             FLUSH,
    output logic             pending,
    output logic [CNT_W-1:0] cnt_mem,
    output logic [CNT_W-1:0] cnt_id,
    output logic [CNT_W-1:0] cnt_pred
);

    localparam int unsigned SH_W = (SHADOW_CYCLES > 0) ? $clog2(SHADOW_CYCLES + 1) : 1;

    // Encoded so a larger value means higher priority.
    typedef enum logic [1:0] {SRC_NONE = 2'd0, SRC_PRED = 2'd1, SRC_ID = 2'd2, SRC_MEM = 2'd3} src_e;
    // Bit 1 = hold active, bit 0 = shadow window active.
    typedef enum logic [1:0] {IDLE = 2'b00, SHADOW = 2'b01, HOLD = 2'b10, HOLD_SHADOW = 2'b11} state_e;

    state_e            state_q, state_d;
    src_e              held_src_q, held_src_d;
    logic [31:0]       held_pc_q, held_pc_d;
    logic [SH_W-1:0]   shadow_q, shadow_d;
    logic              req_q, req_d;
    logic              flush_q, flush_d;
    logic [31:0]       alt_pc_q, alt_pc_d;
    logic [CNT_W-1:0]  cnt_mem_q, cnt_mem_d;
    logic [CNT_W-1:0]  cnt_id_q, cnt_id_d;
    logic [CNT_W-1:0]  cnt_pred_q, cnt_pred_d;

    src_e              in_src, win_src;
    logic [31:0]       in_pc, win_pc;
    logic              hold_d;
    logic              hold_active;
    logic              shadow_active;

    assign hold_active   = state_q[1];
    assign shadow_active = state_q[0];

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    // Next-state: eligibility, winner selection, hold/issue and shadow bookkeeping.
    always_comb begin
        held_src_d = held_src_q;
        held_pc_d  = held_pc_q;
        shadow_d   = shadow_q;
        req_d      = 1'b0;
        flush_d    = 1'b0;
        alt_pc_d   = alt_pc_q;
        cnt_mem_d  = cnt_mem_q;
        cnt_id_d   = cnt_id_q;
        cnt_pred_d = cnt_pred_q;
        hold_d     = hold_active;
        in_src     = SRC_NONE;
        in_pc      = 32'h0;

        // Younger-stage requests are wrong-path while the shadow window is open.
        if (mem_redirect_valid) begin
            in_src = SRC_MEM;
            in_pc  = mem_redirect_pc;
        end else if (id_redirect_valid && !shadow_active) begin
            in_src = SRC_ID;
            in_pc  = id_redirect_pc;
        end else if (pred_valid && !shadow_active) begin
            in_src = SRC_PRED;
            in_pc  = pred_pc;
        end

        win_src = in_src;
        win_pc  = in_pc;
        // Held request wins unless a strictly higher-priority source arrives.
        if (hold_active && !(in_src > held_src_q)) begin
            win_src = held_src_q;
            win_pc  = held_pc_q;
        end

        if (win_src != SRC_NONE) begin
            if (!STALL) begin
                req_d      = 1'b1;
                alt_pc_d   = win_pc;
                flush_d    = (win_src != SRC_PRED);
                hold_d     = 1'b0;
                held_src_d = SRC_NONE;
                if (shadow_active) begin
                    shadow_d = shadow_q - SH_W'(1);
                end
                case (win_src)
                    SRC_MEM: begin
                        cnt_mem_d = sat_inc(cnt_mem_q);
                        shadow_d  = SH_W'(SHADOW_CYCLES);
                    end
                    SRC_ID:   cnt_id_d   = sat_inc(cnt_id_q);
                    SRC_PRED: cnt_pred_d = sat_inc(cnt_pred_q);
                    default:  ;
                endcase
            end else begin
                held_src_d = win_src;
                held_pc_d  = win_pc;
                hold_d     = 1'b1;
            end
        end else if (!STALL && shadow_active) begin
            shadow_d = shadow_q - SH_W'(1);
        end

        state_d = state_e'({hold_d, (shadow_d != '0)});
    end

    // State and registered outputs.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= IDLE;
            held_src_q <= SRC_NONE;
            held_pc_q  <= 32'h0;
            shadow_q   <= '0;
            req_q      <= 1'b0;
            flush_q    <= 1'b0;
            alt_pc_q   <= 32'h0;
            cnt_mem_q  <= '0;
            cnt_id_q   <= '0;
            cnt_pred_q <= '0;
        end else begin
            state_q    <= state_d;
            held_src_q <= held_src_d;
            held_pc_q  <= held_pc_d;
            shadow_q   <= shadow_d;
            req_q      <= req_d;
            flush_q    <= flush_d;
            alt_pc_q   <= alt_pc_d;
            cnt_mem_q  <= cnt_mem_d;
            cnt_id_q   <= cnt_id_d;
            cnt_pred_q <= cnt_pred_d;
        end
    end

    assign Request_Alt_PC = req_q;
    assign Alt_PC         = alt_pc_q;
    assign FLUSH          = flush_q;
    assign pending        = state_q[1];
    assign cnt_mem        = cnt_mem_q;
    assign cnt_id         = cnt_id_q;
    assign cnt_pred       = cnt_pred_q;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed bench for fetch_redirect_ctrl: priority, shadow window, stall hold,
// async reset during hold, and counter saturation.
module tb_fetch_redirect_ctrl;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        STALL;
    logic        mem_redirect_valid;
    logic [31:0] mem_redirect_pc;
    logic        id_redirect_valid;
    logic [31:0] id_redirect_pc;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        Request_Alt_PC;
    logic [31:0] Alt_PC;
    logic        FLUSH;
    logic        pending;
    logic [15:0] cnt_mem;
    logic [15:0] cnt_id;
    logic [15:0] cnt_pred;

    int errors = 0;
    int checks = 0;

    fetch_redirect_ctrl dut (
        .CLK                (CLK),
        .RESET              (RESET),
        .STALL              (STALL),
        .mem_redirect_valid (mem_redirect_valid),
        .mem_redirect_pc    (mem_redirect_pc),
        .id_redirect_valid  (id_redirect_valid),
        .id_redirect_pc     (id_redirect_pc),
        .pred_valid         (pred_valid),
        .pred_pc            (pred_pc),
        .Request_Alt_PC     (Request_Alt_PC),
        .Alt_PC             (Alt_PC),
        .FLUSH              (FLUSH),
        .pending            (pending),
        .cnt_mem            (cnt_mem),
        .cnt_id             (cnt_id),
        .cnt_pred           (cnt_pred)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; leave time 1 unit past the edge for checks/drive.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        mem_redirect_valid = 1'b0;
        id_redirect_valid  = 1'b0;
        pred_valid         = 1'b0;
    endtask

    initial begin
        RESET = 1'b0;
        STALL = 1'b0;
        mem_redirect_pc = 32'h0;
        id_redirect_pc  = 32'h0;
        pred_pc         = 32'h0;
        clear_inputs();
        tick();
        tick();
        chk("rst_req", 32'(Request_Alt_PC), 32'd0);
        chk("rst_flush", 32'(FLUSH), 32'd0);
        chk("rst_alt", Alt_PC, 32'h0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_cnts", {cnt_mem, cnt_id} | 32'(cnt_pred), 32'd0);
        RESET = 1'b1;
        tick();

        // Single ID redirect.
        id_redirect_valid = 1'b1;
        id_redirect_pc    = 32'h0040_0100;
        tick();
        chk("id_req", 32'(Request_Alt_PC), 32'd1);
        chk("id_alt", Alt_PC, 32'h0040_0100);
        chk("id_flush", 32'(FLUSH), 32'd1);
        chk("id_cnt", 32'(cnt_id), 32'd1);
        clear_inputs();
        tick();
        chk("id_req_drop", 32'(Request_Alt_PC), 32'd0);
        chk("id_alt_hold", Alt_PC, 32'h0040_0100);

        // All three at once: MEM wins, then 2-cycle shadow blocks ID.
        mem_redirect_valid = 1'b1;
        mem_redirect_pc    = 32'h0040_0200;
        id_redirect_valid  = 1'b1;
        id_redirect_pc     = 32'h0040_0300;
        pred_valid         = 1'b1;
        pred_pc            = 32'h0040_0400;
        tick();
        chk("all_alt", Alt_PC, 32'h0040_0200);
        chk("all_flush", 32'(FLUSH), 32'd1);
        chk("all_cnt_mem", 32'(cnt_mem), 32'd1);
        chk("all_cnt_id", 32'(cnt_id), 32'd1);
        chk("all_cnt_pred", 32'(cnt_pred), 32'd0);
        mem_redirect_valid = 1'b0;
        pred_valid         = 1'b0;
        tick();
        chk("shadow1_req", 32'(Request_Alt_PC), 32'd0);
        tick();
        chk("shadow2_req", 32'(Request_Alt_PC), 32'd0);
        chk("shadow2_cnt_id", 32'(cnt_id), 32'd1);
        tick();
        chk("post_shadow_req", 32'(Request_Alt_PC), 32'd1);
        chk("post_shadow_alt", Alt_PC, 32'h0040_0300);
        chk("post_shadow_cnt_id", 32'(cnt_id), 32'd2);
        clear_inputs();

        // Predictor redirect: no flush.
        pred_valid = 1'b1;
        pred_pc    = 32'h0040_0500;
        tick();
        chk("pred_req", 32'(Request_Alt_PC), 32'd1);
        chk("pred_alt", Alt_PC, 32'h0040_0500);
        chk("pred_flush", 32'(FLUSH), 32'd0);
        chk("pred_cnt", 32'(cnt_pred), 32'd1);
        clear_inputs();
        tick();

        // Stall hold: PRED held, replaced by higher-priority ID, issued once.
        STALL      = 1'b1;
        pred_valid = 1'b1;
        pred_pc    = 32'h0040_0040;
        tick();
        chk("stall1_pending", 32'(pending), 32'd1);
        chk("stall1_req", 32'(Request_Alt_PC), 32'd0);
        pred_valid        = 1'b0;
        id_redirect_valid = 1'b1;
        id_redirect_pc    = 32'h0040_0080;
        tick();
        chk("stall2_pending", 32'(pending), 32'd1);
        chk("stall2_req", 32'(Request_Alt_PC), 32'd0);
        id_redirect_valid = 1'b0;
        tick();
        chk("stall3_pending", 32'(pending), 32'd1);
        chk("stall3_req", 32'(Request_Alt_PC), 32'd0);
        STALL = 1'b0;
        tick();
        chk("release_req", 32'(Request_Alt_PC), 32'd1);
        chk("release_alt", Alt_PC, 32'h0040_0080);
        chk("release_flush", 32'(FLUSH), 32'd1);
        chk("release_pending", 32'(pending), 32'd0);
        chk("release_cnt_pred", 32'(cnt_pred), 32'd1);
        chk("release_cnt_id", 32'(cnt_id), 32'd3);
        tick();
        chk("release_once", 32'(Request_Alt_PC), 32'd0);

        // Async reset while holding an ID request.
        STALL             = 1'b1;
        id_redirect_valid = 1'b1;
        id_redirect_pc    = 32'h0040_0900;
        tick();
        chk("rhold_pending", 32'(pending), 32'd1);
        id_redirect_valid = 1'b0;
        #2;
        RESET = 1'b0;
        #1;
        chk("arst_pending", 32'(pending), 32'd0);
        chk("arst_req", 32'(Request_Alt_PC), 32'd0);
        chk("arst_cnt_id", 32'(cnt_id), 32'd0);
        chk("arst_cnt_mem", 32'(cnt_mem), 32'd0);
        tick();
        RESET = 1'b1;
        STALL = 1'b0;
        tick();
        chk("arst_after_req", 32'(Request_Alt_PC), 32'd0);
        tick();
        chk("arst_after_req2", 32'(Request_Alt_PC), 32'd0);
        chk("arst_after_pending", 32'(pending), 32'd0);

        // Saturation of the predictor counter.
        pred_valid = 1'b1;
        pred_pc    = 32'h0040_0c00;
        for (int i = 0; i < 65534; i++) tick();
        chk("sat_fffe", 32'(cnt_pred), 32'h0000_fffe);
        chk("sat_fffe_flush", 32'(FLUSH), 32'd0);
        tick();
        chk("sat_ffff", 32'(cnt_pred), 32'h0000_ffff);
        tick();
        chk("sat_hold", 32'(cnt_pred), 32'h0000_ffff);
        chk("sat_req", 32'(Request_Alt_PC), 32'd1);
        chk("sat_flush", 32'(FLUSH), 32'd0);
        chk("sat_cnt_mem", 32'(cnt_mem), 32'd0);
        clear_inputs();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
